prbs_channel_tx: RTL

// - Transmit-side stimulus source for the receive datapath: generates WIDTH PRBS7 bits per clk and

---
 rtl/prbs_channel_tx.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/prbs_channel_tx.sv
// prbs_channel_tx: WIDTH-lane PRBS7 source convolved with a programmable post-cursor channel into
// saturated signed codes. Define PRBS_TX_NOISE_EN to add a PRBS9 dither source and a noise_on port.
module prbs_channel_tx #(
    parameter int WIDTH      = 16,
    parameter int CODE_BITS  = 8,
    parameter int TAP_DEPTH  = 4,
    parameter int TAP_BITS   = 8,
    parameter int SHIFT_BITS = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 en,
    input  logic                                 seed_load,
    input  logic [6:0]                           seed,
    input  logic [TAP_DEPTH-1:0][TAP_BITS-1:0]   taps,
    input  logic [SHIFT_BITS-1:0]                shift,
`ifdef PRBS_TX_NOISE_EN
    input  logic                                 noise_on,
`endif
    output logic [WIDTH-1:0]                     bits_out,
    output logic [WIDTH-1:0][CODE_BITS-1:0]      codes_out,
    output logic                                 valid_out
);
    localparam int HIST_BITS = TAP_DEPTH - 1;
    localparam int SUM_BITS  = TAP_BITS + $clog2(TAP_DEPTH) + 1;
    localparam logic signed [SUM_BITS-1:0] CODE_MAX = SUM_BITS'((1 << (CODE_BITS - 1)) - 1);
    localparam logic signed [SUM_BITS-1:0] CODE_MIN = SUM_BITS'(-(1 << (CODE_BITS - 1)));

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t                          state_q, state_d;
    logic [6:0]                      lfsr_q, lfsr_d, prbs_step;
    logic [WIDTH-1:0]                cur_blk_q, cur_blk_d, blk_new;
    logic [HIST_BITS-1:0]            hist_q, hist_d;
    logic                            stage1_vld_q, stage1_vld_d;
    logic [WIDTH-1:0]                bits_q, bits_d;
    logic [WIDTH-1:0][CODE_BITS-1:0] codes_q, codes_d, codes_sat;
    logic                            valid_q, valid_d;
    logic                            advance;
    logic [WIDTH+HIST_BITS-1:0]      ext_bits;

    // WIDTH unrolled PRBS7 steps; lane k carries the output of step k.
    always_comb begin
        prbs_step = lfsr_q;
        blk_new   = '0;
        for (int k = 0; k < WIDTH; k++) begin
            blk_new[k] = prbs_step[6] ^ prbs_step[5];
            prbs_step  = {prbs_step[5:0], blk_new[k]};
        end
    end

    assign advance = en && !seed_load && (state_q != IDLE);

    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        cur_blk_d    = cur_blk_q;
        hist_d       = hist_q;
        stage1_vld_d = 1'b0;
        if (seed_load) begin
            lfsr_d  = (seed == 7'h00) ? 7'h7F : seed;
            hist_d  = '0;
            state_d = PRIME;
        end else if (en) begin
            case (state_q)
                // The primed block parks in cur_blk with stage1_vld low, so it is never emitted
                // and becomes the history of the first RUN block.
                PRIME: begin
                    lfsr_d    = prbs_step;
                    cur_blk_d = blk_new;
                    state_d   = RUN;
                end
                RUN: begin
                    lfsr_d       = prbs_step;
                    cur_blk_d    = blk_new;
                    hist_d       = cur_blk_q[WIDTH-1 -: HIST_BITS];
                    stage1_vld_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef PRBS_TX_NOISE_EN
    logic [8:0]             noise_q, noise_d, noise_step;
    logic [WIDTH-1:0][1:0]  dither;
    logic                   noise_bit;

    always_comb begin
        noise_step = noise_q;
        noise_bit  = 1'b0;
        dither     = '0;
        for (int k = 0; k < WIDTH; k++) begin
            noise_bit  = noise_step[8] ^ noise_step[4];
            noise_step = {noise_step[7:0], noise_bit};
            dither[k]  = noise_on ? noise_step[1:0] : 2'b00;
        end
        noise_d = advance ? noise_step : noise_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            noise_q <= 9'h1FF;
        end else begin
            noise_q <= noise_d;
        end
    end
`endif

    // History sits below the current block so lane k, tap j reads ext_bits[k + HIST_BITS - j].
    assign ext_bits = {cur_blk_q, hist_q};

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
        logic signed [SUM_BITS-1:0] term [TAP_DEPTH];
        logic signed [SUM_BITS-1:0] sum, shifted, total;
        logic [CODE_BITS-1:0]       code;

        for (genvar gj = 0; gj < TAP_DEPTH; gj++) begin : g_tap
            logic signed [SUM_BITS-1:0] tap_ext;
            assign tap_ext  = {{(SUM_BITS - TAP_BITS){taps[gj][TAP_BITS-1]}}, taps[gj]};
            assign term[gj] = ext_bits[gi + HIST_BITS - gj] ? tap_ext : -tap_ext;
        end

        always_comb begin
            sum = '0;
            for (int j = 0; j < TAP_DEPTH; j++) begin
                sum = sum + term[j];
            end
            shifted = sum >>> shift;
`ifdef PRBS_TX_NOISE_EN
            total = shifted + {{(SUM_BITS - 2){dither[gi][1]}}, dither[gi]};
`else
            total = shifted;
`endif
            if (total > CODE_MAX) begin
                code = CODE_MAX[CODE_BITS-1:0];
            end else if (total < CODE_MIN) begin
                code = CODE_MIN[CODE_BITS-1:0];
            end else begin
                code = total[CODE_BITS-1:0];
            end
        end

        assign codes_sat[gi] = code;
    end

    always_comb begin
        bits_d  = cur_blk_q;
        codes_d = codes_sat;
        valid_d = stage1_vld_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            lfsr_q       <= 7'h7F;
            cur_blk_q    <= '0;
            hist_q       <= '0;
            stage1_vld_q <= 1'b0;
            bits_q       <= '0;
            codes_q      <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            cur_blk_q    <= cur_blk_d;
            hist_q       <= hist_d;
            stage1_vld_q <= stage1_vld_d;
            bits_q       <= bits_d;
            codes_q      <= codes_d;
            valid_q      <= valid_d;
        end
    end

    assign bits_out  = bits_q;
    assign codes_out = codes_q;
    assign valid_out = valid_q;
endmodule
